// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO bus controller: address decode, registered LED/segment write
// strobes, and enter-button handshaked switch reads with an optional timeout.
module io_bus_ctrl #(
  parameter logic [31:0] SW_ADDR        = 32'hFFFF_FFF0,
  parameter logic [31:0] LED_ADDR       = 32'hFFFF_FFF4,
  parameter logic [31:0] SEG_ADDR       = 32'hFFFF_FFF7,
  parameter logic [31:0] STAT_ADDR      = 32'hFFFF_FFF8,
  parameter bit          WAIT_ENTER     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        enter_debounced,
  input  logic [15:0] switch_data,
  output logic        io_hit,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        led_we,
  output logic [15:0] led_wdata,
  output logic        seg_we,
  output logic [31:0] seg_wdata
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic          enter_q;
  logic [CW-1:0] tmo_cnt;
  logic          timeout_flag;
  logic [15:0]   cap_data;

  logic          led_go;
  logic          seg_go;
  logic          capture;
  logic          by_press;
  logic          by_timeout;
  logic          press_edge;
  logic          tmo_hit;

  assign io_hit = (cpu_addr == SW_ADDR) || (cpu_addr == LED_ADDR) ||
                  (cpu_addr == SEG_ADDR) || (cpu_addr == STAT_ADDR);
  assign press_edge = enter_debounced & ~enter_q;
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  // Next-state, stall and read-response logic
  always_comb begin
    state_next = state;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = 32'h0000_0000;
    led_go     = 1'b0;
    seg_go     = 1'b0;
    capture    = 1'b0;
    by_press   = 1'b0;
    by_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          // A store on an IO address wins over a simultaneous load.
          led_go = (cpu_addr == LED_ADDR);
          seg_go = (cpu_addr == SEG_ADDR);
        end else if (cpu_rd && (cpu_addr == STAT_ADDR)) begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = {29'b0, timeout_flag, enter_debounced, 1'b0};
        end else if (cpu_rd && (cpu_addr == SW_ADDR)) begin
          if (WAIT_ENTER) begin
            cpu_stall  = 1'b1;
            state_next = enter_debounced ? WAIT_REL : WAIT_PRESS;
          end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = {16'b0, switch_data};
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_REL: begin
        cpu_stall = 1'b1;
        if (tmo_hit) begin
          capture    = 1'b1;
          by_timeout = 1'b1;
          state_next = RESP;
        end else if (!enter_debounced) begin
          state_next = WAIT_PRESS;
        end else begin
          state_next = WAIT_REL;
        end
      end
      WAIT_PRESS: begin
        cpu_stall = 1'b1;
        if (press_edge) begin
          capture    = 1'b1;
          by_press   = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          capture    = 1'b1;
          by_timeout = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT_PRESS;
        end
      end
      RESP: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = {16'b0, cap_data};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      cpu_stall  = 1'b0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = 32'h0000_0000;
    end else begin
      cpu_stall  = cpu_stall;
    end
  end

  // State, strobe, capture and timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      enter_q      <= 1'b0;
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
      cap_data     <= 16'h0000;
      led_we       <= 1'b0;
      seg_we       <= 1'b0;
      led_wdata    <= 16'h0000;
      seg_wdata    <= 32'h0000_0000;
    end else begin
      state   <= state_next;
      enter_q <= enter_debounced;
      led_we  <= led_go;
      seg_we  <= seg_go;
      if (led_go) led_wdata <= cpu_wdata[15:0];
      if (seg_go) seg_wdata <= cpu_wdata;
      if ((state == WAIT_REL) || (state == WAIT_PRESS)) tmo_cnt <= tmo_cnt + CW'(1);
      else                                              tmo_cnt <= '0;
      if (capture) cap_data <= switch_data;
      if (by_press)        timeout_flag <= 1'b0;
      else if (by_timeout) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: two instances (no timeout / 8-cycle timeout) share the
// stimulus and are checked every cycle against a transaction-level model.
module tb_io_bus_ctrl;

  localparam logic [31:0] SW   = 32'hFFFF_FFF0;
  localparam logic [31:0] LED  = 32'hFFFF_FFF4;
  localparam logic [31:0] SEG  = 32'hFFFF_FFF7;
  localparam logic [31:0] STAT = 32'hFFFF_FFF8;
  localparam int TMO_B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        enter = 1'b0;
  logic [15:0] sw = 16'h0;

  logic        hit_o    [2];
  logic        stall_o  [2];
  logic [31:0] rdata_o  [2];
  logic        rvalid_o [2];
  logic        led_we_o [2];
  logic [15:0] led_d_o  [2];
  logic        seg_we_o [2];
  logic [31:0] seg_d_o  [2];

  int tests = 0;
  int fails = 0;
  int sc;

  always #5 clk = ~clk;

  io_bus_ctrl #(.TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .enter_debounced(enter), .switch_data(sw), .io_hit(hit_o[0]),
    .cpu_stall(stall_o[0]), .cpu_rdata(rdata_o[0]), .cpu_rvalid(rvalid_o[0]),
    .led_we(led_we_o[0]), .led_wdata(led_d_o[0]), .seg_we(seg_we_o[0]), .seg_wdata(seg_d_o[0]));

  io_bus_ctrl #(.TIMEOUT_CYCLES(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .enter_debounced(enter), .switch_data(sw), .io_hit(hit_o[1]),
    .cpu_stall(stall_o[1]), .cpu_rdata(rdata_o[1]), .cpu_rvalid(rvalid_o[1]),
    .led_we(led_we_o[1]), .led_wdata(led_d_o[1]), .seg_we(seg_we_o[1]), .seg_wdata(seg_d_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a read is outstanding (busy), possibly still waiting for the button
  // to be let go (need_rel); the answer is shown for one cycle (resp).
  bit          model_ok = 1'b0;
  bit          prev_enter = 1'b0;
  bit          busy [2] = '{1'b0, 1'b0};
  bit          need_rel [2] = '{1'b0, 1'b0};
  bit          resp [2] = '{1'b0, 1'b0};
  bit          tflag [2] = '{1'b0, 1'b0};
  int          waited [2] = '{0, 0};
  logic [15:0] cap [2] = '{16'h0, 16'h0};
  bit          m_led_we [2] = '{1'b0, 1'b0};
  bit          m_seg_we [2] = '{1'b0, 1'b0};
  logic [15:0] m_led_d [2] = '{16'h0, 16'h0};
  logic [31:0] m_seg_d [2] = '{32'h0, 32'h0};

  function automatic int tmo_of(input int k);
    return (k == 1) ? TMO_B : 0;
  endfunction

  always @(posedge clk) begin
    model_ok   <= model_ok | rst;
    prev_enter <= rst ? 1'b0 : enter;
    for (int k = 0; k < 2; k++) begin
      automatic bit          nb = busy[k];
      automatic bit          nr = need_rel[k];
      automatic bit          ns = resp[k];
      automatic bit          nf = tflag[k];
      automatic int          nw = waited[k];
      automatic logic [15:0] ncap = cap[k];
      automatic bit          nlw = 1'b0;
      automatic bit          nsw = 1'b0;
      automatic logic [15:0] nld = m_led_d[k];
      automatic logic [31:0] nsd = m_seg_d[k];
      if (rst) begin
        nb = 1'b0; nr = 1'b0; ns = 1'b0; nf = 1'b0; nw = 0;
        ncap = 16'h0; nld = 16'h0; nsd = 32'h0;
      end else if (resp[k]) begin
        ns = 1'b0;
      end else if (busy[k]) begin
        if (!need_rel[k] && enter && !prev_enter) begin
          ncap = sw; nf = 1'b0; ns = 1'b1; nb = 1'b0;
        end else if (tmo_of(k) > 0 && waited[k] + 1 == tmo_of(k)) begin
          ncap = sw; nf = 1'b1; ns = 1'b1; nb = 1'b0;
        end else begin
          nw = waited[k] + 1;
          if (need_rel[k] && !enter) nr = 1'b0;
        end
      end else if (cpu_wr) begin
        if (addr == LED) begin nlw = 1'b1; nld = wdata[15:0]; end
        if (addr == SEG) begin nsw = 1'b1; nsd = wdata; end
      end else if (cpu_rd && addr == SW) begin
        nb = 1'b1; nr = enter; nw = 0;
      end
      busy[k] <= nb; need_rel[k] <= nr; resp[k] <= ns; tflag[k] <= nf;
      waited[k] <= nw; cap[k] <= ncap; m_led_we[k] <= nlw; m_seg_we[k] <= nsw;
      m_led_d[k] <= nld; m_seg_d[k] <= nsd;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        automatic bit          e_hit = (addr == SW) || (addr == LED) || (addr == SEG) || (addr == STAT);
        automatic bit          e_stall = 1'b0;
        automatic bit          e_rv = 1'b0;
        automatic logic [31:0] e_rd = 32'h0;
        if (!rst) begin
          if (resp[k]) begin
            e_rv = 1'b1; e_rd = {16'h0, cap[k]};
          end else if (busy[k]) begin
            e_stall = 1'b1;
          end else if (cpu_rd && !cpu_wr && addr == STAT) begin
            e_rv = 1'b1; e_rd = {29'h0, tflag[k], enter, 1'b0};
          end else if (cpu_rd && !cpu_wr && addr == SW) begin
            e_stall = 1'b1;
          end
        end
        chk($sformatf("m%0d_io_hit", k), {31'h0, hit_o[k]}, {31'h0, e_hit});
        chk($sformatf("m%0d_stall", k), {31'h0, stall_o[k]}, {31'h0, e_stall});
        chk($sformatf("m%0d_rvalid", k), {31'h0, rvalid_o[k]}, {31'h0, e_rv});
        chk($sformatf("m%0d_rdata", k), rdata_o[k], e_rd);
        chk($sformatf("m%0d_led_we", k), {31'h0, led_we_o[k]}, {31'h0, m_led_we[k]});
        chk($sformatf("m%0d_led_wdata", k), {16'h0, led_d_o[k]}, {16'h0, m_led_d[k]});
        chk($sformatf("m%0d_seg_we", k), {31'h0, seg_we_o[k]}, {31'h0, m_seg_we[k]});
        chk($sformatf("m%0d_seg_wdata", k), seg_d_o[k], m_seg_d[k]);
      end
    end
  end

  initial begin
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, stall_o[0]}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid_o[0]}, 32'h0);
    chk("rst_led", {15'h0, led_we_o[0], led_d_o[0]}, 32'h0);
    chk("rst_seg_d", seg_d_o[0], 32'h0);
    step();

    // LED and segment writes
    addr = LED; wdata = 32'h1234_ABCD; cpu_wr = 1'b1;
    step();
    addr = 32'h0; cpu_wr = 1'b0; #1;
    chk("led_we_pulse", {31'h0, led_we_o[0]}, 32'h1);
    chk("led_wdata", {16'h0, led_d_o[0]}, 32'h0000_ABCD);
    step();
    chk("led_we_drop", {31'h0, led_we_o[0]}, 32'h0);
    chk("led_wdata_hold", {16'h0, led_d_o[0]}, 32'h0000_ABCD);
    addr = SEG; wdata = 32'hDEAD_BEEF; cpu_wr = 1'b1;
    step();
    addr = 32'h0; cpu_wr = 1'b0; #1;
    chk("seg_we_pulse", {31'h0, seg_we_o[0]}, 32'h1);
    chk("seg_wdata", seg_d_o[0], 32'hDEAD_BEEF);
    step();
    chk("seg_we_drop", {31'h0, seg_we_o[0]}, 32'h0);

    // Handshaked read: 11 stalled cycles, then the response
    sw = 16'h00A5; enter = 1'b0; addr = SW; cpu_rd = 1'b1; sc = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) enter = 1'b1;
      #1;
      if (stall_o[0]) sc++;
      chk("hs_no_rvalid", {31'h0, rvalid_o[0]}, 32'h0);
      step();
    end
    #1;
    chk("hs_rvalid", {31'h0, rvalid_o[0]}, 32'h1);
    chk("hs_rdata", rdata_o[0], 32'h0000_00A5);
    chk("hs_unstall", {31'h0, stall_o[0]}, 32'h0);
    chk("hs_stall_count", sc, 32'd11);
    cpu_rd = 1'b0; addr = 32'h0;
    repeat (20) step();
    enter = 1'b0;
    repeat (20) step();

    // Button already held at the request: must release before a press counts
    enter = 1'b1; addr = SW; cpu_rd = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("held_stall", {31'h0, stall_o[0]}, 32'h1);
      chk("held_no_rvalid", {31'h0, rvalid_o[0]}, 32'h0);
      if (i < 2) step();
    end
    enter = 1'b0;
    step(); step();
    sw = 16'hFFFF; enter = 1'b1;
    step();
    #1;
    chk("rel_rvalid", {31'h0, rvalid_o[0]}, 32'h1);
    chk("rel_rdata", rdata_o[0], 32'h0000_FFFF);
    cpu_rd = 1'b0; addr = 32'h0; enter = 1'b0;
    repeat (20) step();

    // Timeout instance: response after the eighth wait cycle, flag in status
    sw = 16'h5A5A; addr = SW; cpu_rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("tmo_stall", {31'h0, stall_o[1]}, 32'h1);
      chk("tmo_no_rvalid", {31'h0, rvalid_o[1]}, 32'h0);
      step();
    end
    #1;
    chk("tmo_rvalid", {31'h0, rvalid_o[1]}, 32'h1);
    chk("tmo_rdata", rdata_o[1], 32'h0000_5A5A);
    addr = STAT;
    step();
    #1;
    chk("tmo_stat", rdata_o[1], 32'h0000_0004);
    cpu_rd = 1'b0; addr = 32'h0;

    // Reset while instance A still waits for a press
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("rst_mid_stall", {31'h0, stall_o[0]}, 32'h0);
    enter = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stray_press", {31'h0, rvalid_o[0]}, 32'h0);
    end
    addr = STAT; cpu_rd = 1'b1; #1;
    chk("stat_after_rst", rdata_o[1], 32'h0000_0002);
    cpu_rd = 1'b0; enter = 1'b0;
    step();

    // Read+write together, then a non-IO address
    addr = LED; wdata = 32'h0000_5555; cpu_wr = 1'b1; cpu_rd = 1'b1; #1;
    chk("rw_no_rvalid", {31'h0, rvalid_o[0]}, 32'h0);
    chk("rw_no_stall", {31'h0, stall_o[0]}, 32'h0);
    step();
    addr = 32'h0000_0100; wdata = 32'hFFFF_FFFF; #1;
    chk("rw_led_we", {31'h0, led_we_o[0]}, 32'h1);
    chk("rw_led_d", {16'h0, led_d_o[0]}, 32'h0000_5555);
    chk("nonio_hit", {31'h0, hit_o[0]}, 32'h0);
    chk("nonio_stall", {31'h0, stall_o[0]}, 32'h0);
    step();
    #1;
    chk("nonio_led_we", {31'h0, led_we_o[0]}, 32'h0);
    chk("nonio_seg_we", {31'h0, seg_we_o[0]}, 32'h0);
    chk("nonio_led_d", {16'h0, led_d_o[0]}, 32'h0000_5555);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Memory-mapped IO bus controller between the CPU load/store port and the IO devices: 16-bit switch input, enter button, 16-bit LED register, 8-digit seven-segment register.
- Decodes IO addresses and produces registered write strobes for LED and segment data.
- Sequences switch reads through an enter-button handshake. The CPU is stalled until the operator presses enter, or until an optional timeout expires.
- Sits between the CPU memory stage and the IO top level; non-IO addresses pass untouched.

Parameters:
SW_ADDR, 32'hFFFF_FFF0, switch read address (data zero-extended to 32 bits)
LED_ADDR, 32'hFFFF_FFF4, LED write address (low 16 bits used)
SEG_ADDR, 32'hFFFF_FFF7, seven-segment write address (all 32 bits, 8 nibbles)
STAT_ADDR, 32'hFFFF_FFF8, status read address
WAIT_ENTER, 1, 1 = switch reads wait for enter press; 0 = immediate
TIMEOUT_CYCLES, 0, 0 = no timeout; N>0 = release a stalled read after N cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_addr  in  32  load/store address
cpu_wdata  in  32  store data
cpu_rd  in  1  load request (held while cpu_stall=1)
cpu_wr  in  1  store request
enter_debounced  in  1  debounced enter button level
switch_data  in  16  switch levels
io_hit  out  1  cpu_addr matches any IO address (combinational)
cpu_stall  out  1  CPU must hold its state
cpu_rdata  out  32  load data
cpu_rvalid  out  1  cpu_rdata valid this cycle
led_we  out  1  one-cycle LED write strobe
led_wdata  out  16  LED data
seg_we  out  1  one-cycle segment write strobe
seg_wdata  out  32  segment data

Behaviour:
- Clock and reset: clk is the only clock; rst is synchronous and active-high.
- Reset (also mid-operation):
  - FSM goes to IDLE.
  - Outputs go to 0: cpu_stall, cpu_rvalid, cpu_rdata, led_we, seg_we, led_wdata, seg_wdata.
  - Internal registers go to 0: enter_q, timeout counter, timeout flag.
- FSM states: IDLE, WAIT_REL, WAIT_PRESS, RESP.
- Writes (IDLE only):
  - cpu_wr with LED_ADDR: next cycle led_we=1 for exactly one cycle, led_wdata=cpu_wdata[15:0].
  - cpu_wr with SEG_ADDR: next cycle seg_we=1 for one cycle, seg_wdata=cpu_wdata.
  - led_wdata and seg_wdata hold their last value between strobes.
  - Writes to SW_ADDR or STAT_ADDR are ignored.
- Immediate reads (IDLE, combinational, same cycle, no stall):
  - STAT_ADDR: cpu_rvalid=1, cpu_rdata={29'b0, timeout_flag, enter_debounced, 1'b0}.
  - SW_ADDR with WAIT_ENTER=0: cpu_rvalid=1, cpu_rdata={16'b0, switch_data}.
- Handshaked read (WAIT_ENTER=1, cpu_rd with SW_ADDR in IDLE):
  - cpu_stall=1 combinationally in the request cycle.
  - Next state is WAIT_REL if enter_debounced=1, else WAIT_PRESS. Timeout counter clears.
  - WAIT_REL: cpu_stall=1; go to WAIT_PRESS when enter_debounced=0. A held button never satisfies a read.
  - WAIT_PRESS: cpu_stall=1; go to RESP on a rising edge (enter_debounced=1 and enter_q=0). switch_data is captured on that edge into cpu_rdata[15:0]; upper bits are 0.
  - RESP: cpu_stall=0, cpu_rvalid=1 for one cycle, cpu_rdata holds the captured value; then IDLE.
  - Latency: RESP is the cycle after the press edge.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments in WAIT_REL and WAIT_PRESS.
  - When the counter reaches TIMEOUT_CYCLES-1 with no edge: capture switch_data, set timeout_flag, go to RESP.
  - timeout_flag clears when the next handshaked read completes by a press.
  - If an edge and the timeout occur in the same cycle, the edge wins (flag not set).
- enter_q is registered every cycle in all states.
- cpu_wr and cpu_rd together on an IO address: the write is performed, the read is dropped (cpu_rvalid=0, no stall).
- cpu_wr is ignored outside IDLE; the CPU is stalled then.
- Non-IO addresses: io_hit=0, no stall, no strobes, cpu_rvalid=0.
- cpu_rdata=0 whenever cpu_rvalid=0.

Test Plan:
- Reset, then cpu_wr LED_ADDR data 32'h1234_ABCD → next cycle led_we=1 for 1 cycle, led_wdata=16'hABCD. Same for SEG_ADDR with 32'hDEAD_BEEF → seg_we pulse, seg_wdata=32'hDEADBEEF.
- switch_data=16'h00A5, cpu_rd SW_ADDR, enter low; stall 10 cycles; raise enter → RESP next cycle: cpu_rvalid=1, cpu_rdata=32'h0000_00A5, cpu_stall=0; stall asserted for all 11 prior cycles.
- Enter already high at request → WAIT_REL, no response. Release, then press with switch_data=16'hFFFF → cpu_rdata=32'h0000_FFFF.
- TIMEOUT_CYCLES=8, no press → cpu_rvalid on the cycle after the 8th wait cycle. A subsequent STAT_ADDR read returns 32'h0000_0004 with enter low.
- Assert rst during WAIT_PRESS → next cycle cpu_stall=0, state IDLE. A later press with no request produces no cpu_rvalid.
- cpu_rd and cpu_wr together at LED_ADDR → led_we pulse, cpu_rvalid=0. Non-IO address 32'h0000_0100 → io_hit=0, no strobes.
